// File: rtl/diff_pkg.sv
// rtl/diff_pkg.sv - shared defaults and the half-difference helper for diff_rr_scheduler
package diff_pkg;

    localparam int DEF_N   = 8;
    localparam int DEF_NCH = 4;
    localparam int HW      = 64;

    // Operands arrive sign-extended to HW bits; callers keep the low N bits, which always hold the result.
    function automatic logic signed [HW-1:0] half_diff(input logic signed [HW-1:0] x,
                                                       input logic signed [HW-1:0] p);
        return (x - p) >>> 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at ptr
module rr_arbiter
    import diff_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int CW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    output logic [NCH-1:0] gnt,
    output logic [CW-1:0]  gnt_idx,
    output logic           any
);

    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = |req;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = CW'(idx);
            end
        end
    end

endmodule

// File: rtl/diff_rr_scheduler.sv
// rtl/diff_rr_scheduler.sv - shares one first-difference datapath among NCH channels
module diff_rr_scheduler
    import diff_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int NCH = DEF_NCH,
    parameter int CW  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [NCH-1:0]   req_valid,
    input  logic [NCH*N-1:0] req_data,
    output logic [NCH-1:0]   req_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [CW-1:0]    out_ch
);

    logic [N-1:0]  prev_q [NCH];
    logic [N-1:0]  prev_d [NCH];
    logic [CW-1:0] rr_q, rr_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic [CW-1:0] out_ch_q, out_ch_d;

    logic [NCH-1:0]        gnt;
    logic [CW-1:0]         gnt_idx;
    logic                  any;
    logic                  can_grant;
    logic                  hs;
    logic [N-1:0]          x;
    logic [N-1:0]          p;
    logic signed [HW-1:0]  x_ext;
    logic signed [HW-1:0]  p_ext;
    logic [N-1:0]          res;

    rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
        .req     (req_valid),
        .ptr     (rr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // Reset is folded in so req_ready reads 0 while reset is held, not just after an edge.
    assign can_grant = reset && !clear && (!out_valid_q || out_ready);
    assign req_ready = can_grant ? gnt : '0;
    assign hs        = can_grant && any;

    assign x     = req_data[int'(gnt_idx)*N +: N];
    assign p     = prev_q[gnt_idx];
    assign x_ext = {{(HW-N){x[N-1]}}, x};
    assign p_ext = {{(HW-N){p[N-1]}}, p};
    assign res   = N'(half_diff(x_ext, p_ext));

    always_comb begin
        prev_d      = prev_q;
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (clear) begin
            for (int i = 0; i < NCH; i++) begin
                prev_d[i] = '0;
            end
            rr_d        = '0;
            out_valid_d = 1'b0;
        end else if (hs) begin
            prev_d[gnt_idx] = x;
            rr_d            = (gnt_idx == CW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
            out_valid_d     = 1'b1;
            out_data_d      = res;
            out_ch_d        = gnt_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                prev_q[i] <= '0;
            end
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            prev_q      <= prev_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_diff_rr_scheduler.sv
// tb/tb_diff_rr_scheduler.sv - scoreboard bench for diff_rr_scheduler
module tb_diff_rr_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;

    int          nvec = 0;
    int          nerr = 0;
    logic [9:0]  exp_q [$];
    logic [9:0]  mon_e;
    bit          mon_en = 1'b1;

    always #5 clk = ~clk;

    diff_rr_scheduler #(.N(8), .NCH(4), .CW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int ch, input logic [7:0] d);
        exp_q.push_back({ch[1:0], d});
    endtask

    // Consumer side: every accepted result is popped and compared in order.
    always @(negedge clk) begin
        if (reset && mon_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_result: got ch%0d data 0x%0h required none", out_ch, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("result {ch,data}", 32'({out_ch, out_data}), 32'(mon_e));
            end
        end
    end

    task automatic run_until_idle();
        int         cyc = 0;
        logic [3:0] g;
        while (req_valid != 4'b0 && cyc < 100) begin
            @(negedge clk);
            g = req_valid & req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~g;
            cyc++;
        end
        if (req_valid != 4'b0) begin
            nvec++;
            nerr++;
            $display("FAIL handshake_timeout: got pending 0x%0h required 0x0", req_valid);
            req_valid = 4'b0;
        end
    endtask

    task automatic send(input int ch, input logic [7:0] d, input logic [7:0] e);
        req_data[ch*8 +: 8] = d;
        req_valid[ch]       = 1'b1;
        push(ch, e);
        run_until_idle();
        check("latency_out_valid", 32'(out_valid), 32'd1);
    endtask

    initial begin
        int         cnt;
        int         cyc;
        logic [3:0] g;

        reset     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'hF;
        req_data  = 32'h0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data",  32'(out_data),  32'd0);
        check("reset_out_ch",    32'(out_ch),    32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        req_valid = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        send(1, 8'h10, 8'h08);
        send(1, 8'h30, 8'h10);

        send(0, 8'h7F, 8'h3F);
        send(0, 8'h80, 8'h80);

        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;

        req_data = {8'h02, 8'hF0, 8'h20, 8'h10};
        push(0, 8'h08); push(1, 8'h10); push(2, 8'hF8); push(3, 8'h01);
        push(0, 8'h00); push(1, 8'h00); push(2, 8'h00); push(3, 8'h00);
        req_valid = 4'hF;
        cnt = 0;
        cyc = 0;
        while (cnt < 8 && cyc < 100) begin
            @(negedge clk);
            g = req_valid & req_ready;
            if (g != 4'b0) cnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        req_valid = 4'h0;
        check("fair_one_per_cycle", 32'(cyc), 32'd8);

        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        req_data[23:16] = 8'h10;
        req_valid = 4'b0100;
        push(2, 8'h10);
        @(negedge clk);
        check("bp_first_grant", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        req_data[23:16] = 8'h50;
        push(2, 8'h20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 32'h0);
            check("bp_out_data",  32'(out_data),  32'h10);
            check("bp_out_ch",    32'(out_ch),    32'd2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        req_valid = 4'h0;
        check("bp_no_bubble", 32'(out_valid), 32'd1);

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        req_data[15:8] = 8'h40;
        req_valid = 4'b0010;
        @(negedge clk);
        check("clr_pre_grant", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        req_data[7:0]   = 8'h06;
        req_data[31:24] = 8'h20;
        req_valid = 4'b1001;
        clear = 1'b1;
        @(negedge clk);
        check("clr_req_ready", 32'(req_ready), 32'h0);
        check("clr_pending",   32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr_dropped", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        push(0, 8'h03);
        push(3, 8'h10);
        run_until_idle();

        @(posedge clk);
        #1;
        mon_en = 1'b0;
        req_data = 32'h7E7E7E7E;
        req_valid = 4'hF;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("areset_out_valid", 32'(out_valid), 32'd0);
        check("areset_req_ready", 32'(req_ready), 32'd0);
        check("areset_out_data",  32'(out_data),  32'd0);
        req_valid = 4'h0;
        @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        send(0, 8'h04, 8'h02);
        send(2, 8'h0A, 8'h05);
        send(3, 8'h7E, 8'h3F);

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/diff_rr_scheduler.md
# diff_rr_scheduler

Round-robin scheduler that shares one first-difference datapath among `NCH` sample requesters. Each channel keeps its own previous-sample context, so every channel gets an independent difference stream. The datapath computes `out = (x[n] - x[n-1]) / 2`. The block sits between the per-channel sample sources and a single downstream consumer, and tags each result with its channel number.

## Interface
Parameters:
- `N`, default 8: sample and result width, in bits.
- `NCH`, default 4: number of requester channels (at least 2).
- `CW`, default `$clog2(NCH)`: width of the channel index.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset (asserted when 0).
- `clear`, input, 1: synchronous flush of all contexts and any pending output.
- `req_valid`, input, NCH: channel *i* has a sample available.
- `req_data`, input, NCH*N: channel *i* sample at bits [i*N +: N], two's complement.
- `req_ready`, output, NCH: one-hot grant; a sample transfers when `req_valid[i] & req_ready[i]`.
- `out_valid`, output, 1: result register holds a valid result.
- `out_ready`, input, 1: consumer accepts the result.
- `out_data`, output, N: difference result, two's complement.
- `out_ch`, output, CW: channel that produced `out_data`.

## Operation
- Per-channel context `prev[i]` (N bits), reset value 0. The first sample after reset or `clear` is therefore differenced against 0.
- Round-robin pointer `rr` (CW bits), reset value 0. The grant goes to the first requesting channel at or after `rr`, searching in increasing index order with wrap-around.
- `req_ready` is nonzero only when all of these hold:
  - `clear` = 0;
  - some `req_valid` bit is 1;
  - the result register can load, i.e. `!out_valid || out_ready`.
- `req_ready` depends combinationally on `req_valid`, `out_valid`, `out_ready` and `clear`. It must not depend on `req_data`.
- On a handshake for channel g, all of the following happen at the next edge:
  - compute `d = sext(x) - sext(prev[g])` in N+1 bits;
  - load `out_data = d >>> 1`. This is an arithmetic shift, rounding toward −∞, and the result always fits in N bits;
  - `out_ch` = g, `out_valid` = 1;
  - `prev[g]` = x;
  - `rr` = g+1 modulo NCH.
- The result register holds its value while `out_valid & !out_ready`. When `out_ready` is 1 and no new handshake occurs, `out_valid` drops to 0.
- Simultaneous drain and accept: when `out_ready` = 1 and a new handshake occur in the same cycle, the register is replaced with no bubble. Full throughput is one result per cycle.
- A channel that is not granted keeps `req_valid` high. Its data is held and never dropped.
- `clear` = 1:
  - next edge: every `prev` = 0, `rr` = 0, `out_valid` = 0 (a pending result is discarded);
  - no handshake occurs in a cycle where `clear` is 1.
- `reset` low, at any time including mid-transfer: all state returns immediately to reset values.
  - Reset outputs: `out_valid` = 0, `out_data` = 0, `out_ch` = 0, `req_ready` = 0.
  - Deassertion is synchronized externally; the block only requires it to be glitch-free.

## Timing
- Latency: a handshake in cycle t makes `out_valid` = 1 with the result in cycle t+1.
- Arbitration is combinational from `req_valid` and registered `rr`; there is no cycle spent in grant.
- Outputs `out_*` come directly from registers.
- Backpressure: with `out_valid` = 1 and `out_ready` = 0, all `req_ready` = 0. The result is stable until accepted.
- Fairness: with all channels valid continuously and `out_ready` = 1, grants cycle 0,1,…,NCH-1,0,… Each channel is served exactly once per NCH cycles.

## Structure
- Shared package `diff_pkg`:
  - default `N` and `NCH`;
  - the function `half_diff(x, p)`, which returns the N-bit `(sext(x) - sext(p)) >>> 1`.
- Sub-module `rr_arbiter`:
  - parameter `NCH`;
  - inputs `req` [NCH] and `ptr` [CW];
  - outputs `gnt` (one-hot) [NCH], `gnt_idx` [CW] and `any`;
  - purely combinational.
- Top level holds the context array, the `rr` register and the result register.

## Test plan
- Reset, single channel:
  - after reset, ch1 sends 0x10 then 0x30;
  - required: `out_data` = 0x08, then 0x10, `out_ch` = 1 each time, each result one cycle after its handshake.
- Signed extremes:
  - ch0 sends 0x7F; then ch0 sends 0x80 (prev 0x7F);
  - required: 0x3F for the first sample; the second gives d = −255, so `out_data` = 0x80 (−128).
- Fairness:
  - all four channels valid continuously, `out_ready` = 1;
  - required: `out_ch` sequence 0,1,2,3,0,…, one result per cycle, each channel's context independent.
- Backpressure:
  - hold `out_ready` = 0 for 5 cycles with ch2 valid;
  - required: `req_ready` = 0, and `out_data`/`out_ch` stable;
  - on release: same-cycle replace, with no lost or duplicated sample.
- Clear:
  - assert `clear` while `out_valid` = 1 and ch3 is valid;
  - required: result dropped, no handshake; the next ch3 sample 0x20 gives 0x10 (prev = 0), and `rr` restarts at 0.
- Asynchronous reset mid-stream:
  - drive `reset` low between edges during continuous traffic;
  - required: `out_valid` = 0 immediately without waiting for an edge, and all contexts zero afterwards.
